// File: rtl/mac_accumulator.sv
// -----------------------------------------------------------------------------
// mac_accumulator
//
// Purpose
//   Datapath stage that sits behind the MAC sequencer. It captures one operand
//   pair per sequencer phase and computes
//     RESULT = A1*B1 + A2*B2 + A3*B3
//   in a three-stage pipeline: capture, multiply, accumulate. Each completed
//   sequence produces a one-cycle DONE pulse. RESULT is updated on the same
//   edge as DONE.
//
// Parameters
//   WIDTH      unsigned operand width
//   ACC_WIDTH  accumulator and RESULT width. If this is narrower than the full
//              sum needs, the sum saturates at all-ones and OVF reports it.
//
// Ports
//   clk     in   1          system clock, rising edge
//   RST     in   1          synchronous reset, active-high
//   EN      in   1          sequencer enable; when low, a bubble is captured
//   PHASE   in   3          one-hot phase: 001=term1, 010=term2, 100=term3
//   A       in   WIDTH      operand A, sampled on the capture edge
//   B       in   WIDTH      operand B, sampled on the capture edge
//   RESULT  out  ACC_WIDTH  last completed sum, held until the next completion
//   DONE    out  1          one-cycle completion pulse
//   OVF     out  1          the sum published with DONE saturated; held to next DONE
//
// Timing
//   A phase-3 capture on edge t makes RESULT and DONE valid after edge t+2.
//   The pipeline never stalls. EN low or a PHASE that is not one-hot only
//   inserts a bubble, so a pause between phases keeps the partial sum.
// -----------------------------------------------------------------------------
module mac_accumulator #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 2*WIDTH+2
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 EN,
  input  logic [2:0]           PHASE,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [ACC_WIDTH-1:0] RESULT,
  output logic                 DONE,
  output logic                 OVF
);

  localparam int PROD_W = 2*WIDTH;
  // The sum is one bit wider than the wider of the accumulator and the product.
  // That extra bit always holds a carry, so overflow is a plain compare.
  localparam int SUM_W  = ((ACC_WIDTH > PROD_W) ? ACC_WIDTH : PROD_W) + 1;

  // ---------------------------------------------------------------------------
  // Stage 1: capture
  // ---------------------------------------------------------------------------
  logic             w_phase_ok;
  logic [WIDTH-1:0] r_a1;
  logic [WIDTH-1:0] r_b1;
  logic [2:0]       r_tag1;
  logic             r_v1;

  always_comb begin
    w_phase_ok = 1'b0;
    case (PHASE)
      3'b001, 3'b010, 3'b100: w_phase_ok = 1'b1;
      default:                w_phase_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_a1   <= '0;
      r_b1   <= '0;
      r_tag1 <= '0;
      r_v1   <= 1'b0;
    end else begin
      r_v1 <= EN & w_phase_ok;
      if (EN & w_phase_ok) begin
        r_a1   <= A;
        r_b1   <= B;
        r_tag1 <= PHASE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: multiply (full-width product)
  // ---------------------------------------------------------------------------
  logic [PROD_W-1:0] w_prod;
  logic [PROD_W-1:0] r_p2;
  logic [2:0]        r_tag2;
  logic              r_v2;

  assign w_prod = PROD_W'(r_a1) * PROD_W'(r_b1);

  always_ff @(posedge clk) begin
    if (RST) begin
      r_p2   <= '0;
      r_tag2 <= '0;
      r_v2   <= 1'b0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_p2   <= w_prod;
        r_tag2 <= r_tag1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: saturating accumulate and publish
  // ---------------------------------------------------------------------------
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_sat;
  logic [ACC_WIDTH-1:0] r_result;
  logic                 r_done;
  logic                 r_ovf;

  logic [SUM_W-1:0]     w_base;
  logic [SUM_W-1:0]     w_sum;
  logic [SUM_W-1:0]     w_max;
  logic                 w_over;
  logic [ACC_WIDTH-1:0] w_acc_next;
  logic                 w_sat_next;
  logic                 w_acc_en;
  logic                 w_finish;

  // Term 1 restarts the sum from zero. Any stale partial sum is dropped.
  assign w_base     = r_tag2[0] ? '0 : SUM_W'(r_acc);
  assign w_sum      = w_base + SUM_W'(r_p2);
  assign w_max      = SUM_W'({ACC_WIDTH{1'b1}});
  assign w_over     = (w_sum > w_max);
  assign w_acc_next = w_over ? {ACC_WIDTH{1'b1}} : w_sum[ACC_WIDTH-1:0];
  assign w_sat_next = (r_tag2[0] ? 1'b0 : r_sat) | w_over;
  assign w_acc_en   = r_v2 & (|r_tag2);

  // Suppress a publish that would follow directly after another one.
  // This guarantees DONE is never high on two consecutive cycles, even
  // when the same phase-3 term is repeated.
  assign w_finish   = r_v2 & r_tag2[2] & ~r_done;

  always_ff @(posedge clk) begin
    if (RST) begin
      r_acc    <= '0;
      r_sat    <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_acc_en) begin
        r_acc <= w_acc_next;
        r_sat <= w_sat_next;
      end
      if (w_finish) begin
        r_result <= w_acc_next;
        r_ovf    <= w_sat_next;
      end
    end
  end

  assign RESULT = r_result;
  assign DONE   = r_done;
  assign OVF    = r_ovf;

endmodule

// File: tb/tb_mac_accumulator.sv
// -----------------------------------------------------------------------------
// tb_mac_accumulator
//   Drives two instances from the same stimulus:
//     - one with the default 10-bit accumulator
//     - one with an 8-bit accumulator, so that saturation is exercised
//   Expected values come from a transaction-level model. The model applies
//   each captured term immediately with plain saturating arithmetic. It
//   schedules the completion pulse two cycles after the phase-3 capture.
// -----------------------------------------------------------------------------
module tb_mac_accumulator;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [2:0]   phase;
  logic [W-1:0] a;
  logic [W-1:0] b;

  logic [9:0] res10;
  logic       done10;
  logic       ovf10;
  logic [7:0] res8;
  logic       done8;
  logic       ovf8;

  always #5 clk = ~clk;

  mac_accumulator #(.WIDTH(W)) dut10 (
    .clk(clk), .RST(rst), .EN(en), .PHASE(phase), .A(a), .B(b),
    .RESULT(res10), .DONE(done10), .OVF(ovf10)
  );

  mac_accumulator #(.WIDTH(W), .ACC_WIDTH(8)) dut8 (
    .clk(clk), .RST(rst), .EN(en), .PHASE(phase), .A(a), .B(b),
    .RESULT(res8), .DONE(done8), .OVF(ovf8)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    int     cyc;
    longint r0;
    bit     o0;
    longint r1;
    bit     o1;
  } done_t;

  done_t  pend[$];
  longint m_acc  [2];
  bit     m_sat  [2];
  longint m_max  [2] = '{1023, 255};
  longint last_r [2];
  bit     last_o [2];
  int     cyc           = 0;
  int     dones         = 0;
  int     last_done_cyc = 0;
  int     prev_done_cyc = 0;

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_acc[k]  = 0;
      m_sat[k]  = 0;
      last_r[k] = 0;
      last_o[k] = 0;
    end
    pend.delete();
  endtask

  // One clock cycle: apply inputs, model the edge, then check at the negedge.
  task automatic step(input bit r, input bit e, input logic [2:0] p,
                      input logic [W-1:0] aa, input logic [W-1:0] bb);
    longint prod;
    longint s;
    bit     exp_done;
    done_t  d;

    rst   = r;
    en    = e;
    phase = p;
    a     = aa;
    b     = bb;

    @(posedge clk);
    cyc++;
    if (r) begin
      model_clear();
    end else if (e && (p == 3'b001 || p == 3'b010 || p == 3'b100)) begin
      prod = longint'(aa) * longint'(bb);
      for (int k = 0; k < 2; k++) begin
        s = (p == 3'b001) ? prod : m_acc[k] + prod;
        if (p == 3'b001) m_sat[k] = 0;
        if (s > m_max[k]) begin
          m_acc[k] = m_max[k];
          m_sat[k] = 1;
        end else begin
          m_acc[k] = s;
        end
      end
      if (p == 3'b100) begin
        d.cyc = cyc + 2;
        d.r0  = m_acc[0];
        d.o0  = m_sat[0];
        d.r1  = m_acc[1];
        d.o1  = m_sat[1];
        pend.push_back(d);
      end
    end

    @(negedge clk);
    exp_done = 0;
    if (pend.size() > 0 && pend[0].cyc == cyc) begin
      exp_done  = 1;
      last_r[0] = pend[0].r0;
      last_o[0] = pend[0].o0;
      last_r[1] = pend[0].r1;
      last_o[1] = pend[0].o1;
      void'(pend.pop_front());
      dones++;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
    end
    check("done10", 64'(done10), 64'(exp_done));
    check("done8",  64'(done8),  64'(exp_done));
    check("res10",  64'(res10),  64'(last_r[0]));
    check("ovf10",  64'(ovf10),  64'(last_o[0]));
    check("res8",   64'(res8),   64'(last_r[1]));
    check("ovf8",   64'(ovf8),   64'(last_o[1]));
    $display("cyc %0d rst=%0b en=%0b ph=%03b a=%0d b=%0d -> done=%0b res10=%0d ovf10=%0b res8=%0d ovf8=%0b",
             cyc, r, e, p, aa, bb, done10, res10, ovf10, res8, ovf8);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 3'b000, 0, 0);
  endtask

  int          d0;
  logic [2:0]  nxt;
  logic [2:0]  ph;
  bit          er;
  bit          ee;
  bit          last_was3;

  initial begin
    model_clear();
    step(1, 0, 3'b000, 0, 0);
    step(1, 0, 3'b000, 0, 0);
    check("reset_res10", 64'(res10), 64'd0);
    check("reset_done",  64'(done10), 64'd0);

    // Basic sequence
    d0 = dones;
    step(0, 1, 3'b001, 3, 4);
    step(0, 1, 3'b010, 5, 6);
    step(0, 1, 3'b100, 7, 8);
    idle(3);
    check("t1_res",   64'(res10), 64'd98);
    check("t1_ovf",   64'(ovf10), 64'd0);
    check("t1_dones", 64'(dones - d0), 64'd1);

    // Maximum operands: exact in 10 bits, saturated in 8 bits
    for (int i = 0; i < 3; i++) step(0, 1, 3'(1 << i), 15, 15);
    idle(3);
    check("t2_res10", 64'(res10), 64'd675);
    check("t2_ovf10", 64'(ovf10), 64'd0);
    check("t2_res8",  64'(res8),  64'd255);
    check("t2_ovf8",  64'(ovf8),  64'd1);

    // Sequencer pause between phases 2 and 3
    d0 = dones;
    step(0, 1, 3'b001, 3, 4);
    step(0, 1, 3'b010, 5, 6);
    for (int i = 0; i < 10; i++) step(0, 0, 3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));
    step(0, 1, 3'b100, 7, 8);
    idle(3);
    check("t3_res",   64'(res10), 64'd98);
    check("t3_dones", 64'(dones - d0), 64'd1);

    // Reset mid-sequence, then a clean sequence
    d0 = dones;
    step(0, 1, 3'b001, 3, 4);
    step(0, 1, 3'b010, 5, 6);
    step(1, 0, 3'b000, 0, 0);
    idle(3);
    check("t4_res_rst", 64'(res10), 64'd0);
    check("t4_nodone",  64'(dones - d0), 64'd0);
    step(0, 1, 3'b001, 1, 1);
    step(0, 1, 3'b010, 2, 2);
    step(0, 1, 3'b100, 3, 3);
    idle(3);
    check("t4_res", 64'(res10), 64'd14);

    // Back-to-back sequences with no gap
    d0 = dones;
    for (int i = 0; i < 3; i++) step(0, 1, 3'(1 << i), 1, 2);
    for (int i = 0; i < 3; i++) step(0, 1, 3'(1 << i), 2, 2);
    idle(3);
    check("t5_res",   64'(res10), 64'd12);
    check("t5_dones", 64'(dones - d0), 64'd2);
    check("t5_gap",   64'(last_done_cyc - prev_done_cyc), 64'd3);

    // Non-one-hot phases with EN high are ignored
    step(0, 1, 3'b001, 3, 4);
    step(0, 1, 3'b011, 9, 9);
    step(0, 1, 3'b000, 9, 9);
    step(0, 1, 3'b010, 5, 6);
    step(0, 1, 3'b111, 9, 9);
    step(0, 1, 3'b100, 7, 8);
    idle(3);
    check("t6_res", 64'(res10), 64'd98);

    // Randomised traffic
    nxt       = 3'b001;
    last_was3 = 0;
    for (int i = 0; i < 400; i++) begin
      er = ($urandom_range(0, 99) < 2);
      ee = ($urandom_range(0, 9) < 8);
      ph = ($urandom_range(0, 99) < 85) ? nxt : 3'($urandom_range(0, 7));
      // Avoid two phase-3 captures on consecutive cycles.
      if (last_was3 && ph == 3'b100) ee = 0;
      step(er, ee, ph, 4'($urandom), 4'($urandom));
      last_was3 = !er && ee && (ph == 3'b100);
      if (er) begin
        nxt = 3'b001;
      end else if (ee && ph == nxt) begin
        nxt = (nxt == 3'b100) ? 3'b001 : 3'(nxt << 1);
      end
    end
    idle(4);
    check("pending_empty", 64'(pend.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
